exported_class_method_template: RTL and testbench
=================================================

EXPORTED_CLASS_METHOD_TEMPLATE -- requirements
Module: exported_class_method_template

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, result FIFO entries (power of two, >= 8).
REQ-002 SHALL have parameter PIPE_LATENCY, default 2, multiply pipeline stages (>= 1).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port rst_and_startup_done_out, output, 1, high once the block is ready for traffic.
REQ-006 SHALL have port TimesFive___uint_32___valid_in, input, 1, call request valid.
REQ-007 SHALL have port TimesFive___uint_32___x_in, input, 32, argument x (unsigned).
REQ-008 SHALL have port TimesFive___uint_32___rdy_out, output, 1, call accept ready.
REQ-009 SHALL have port TimesFive___uint_32___rden_in, input, 1, result FIFO pop.
REQ-010 SHALL have port TimesFive___uint_32___empty_out, output, 1, result FIFO empty.
REQ-011 SHALL have port TimesFive___uint_32___result_out, output, 32, head-of-FIFO result (show-ahead).
REQ-012 SHALL have port stall_rate_supported_out, output, 1, stall injection available.
REQ-013 SHALL have port stall_rate_valid_in, input, 1, load stall_rate_in.
REQ-014 SHALL have port stall_rate_in, input, 3, stall rate 0..7 (eighths of cycles).

Function
REQ-015 SHALL accept a call in every cycle where valid_in and rdy_out are both high; valid_in with rdy_out low is ignored.
REQ-016 SHALL compute result = (x * 5) mod 2^32 (x<<2 + x, truncated to 32 bits); 0xFFFFFFFF -> 0xFFFFFFFB.
REQ-017 SHALL deliver results in acceptance order, one result per accepted call, none lost or duplicated.
REQ-018 SHALL make a result visible (empty_out low, result_out valid) exactly PIPE_LATENCY+1 cycles after acceptance when the FIFO was empty.
REQ-019 SHALL present result_out as the FIFO head whenever empty_out is low; result_out is don't-care when empty.
REQ-020 SHALL pop the head on a cycle where rden_in is high and empty_out is low; rden_in while empty is ignored.
REQ-021 SHALL drive rdy_out high only when (FIFO occupancy + in-flight pipeline entries) < FIFO_DEPTH and rst_and_startup_done_out is high and no stall is being injected.
REQ-022 SHALL keep occupancy unchanged on a simultaneous push and pop; a full FIFO never overflows, an empty FIFO never underflows.
REQ-023 SHALL wrap read/write pointers modulo FIFO_DEPTH; an unbounded stream (e.g. 32768 calls with reads stalled arbitrarily) completes correctly.
REQ-024 SHALL, with stall injection enabled and rate R loaded, force rdy_out low during cycles where a free-running 3-bit counter < R; R=0 means no stalls.

Reset
REQ-025 SHALL, while rst is high: rdy_out=0, empty_out=1, rst_and_startup_done_out=0, FIFO and pipeline emptied, stall rate=0, counter=0.
REQ-026 SHALL assert rst_and_startup_done_out exactly 4 cycles after the first cycle rst is sampled low, and hold it high until the next reset.
REQ-027 SHALL abort all in-flight and queued results when rst is asserted mid-operation; none appear after reset.

Configuration
REQ-028 SHALL, with EXPORTED_CLASS_METHOD_TEMPLATE_STALL_INJECT_EN defined, drive stall_rate_supported_out=1 and load stall_rate_in when stall_rate_valid_in is high.
REQ-029 SHALL, without EXPORTED_CLASS_METHOD_TEMPLATE_STALL_INJECT_EN, drive stall_rate_supported_out=0, ignore stall_rate_valid_in/stall_rate_in (X tolerated), never inject stalls.

Structure
REQ-030 SHALL place uint32_t typedef, the multiplier constant 5 and the startup delay constant 4 in a shared package.
REQ-031 SHALL implement the result queue as one sub-module, ecmt_result_fifo (show-ahead, synchronous reset, full/empty/count).

Verification
REQ-032 SHALL cover: put x=0..9 back-to-back, read when non-empty -> results 0,5,10,...,45 in order.
REQ-033 SHALL cover: x=0xFFFFFFFF and x=0x33333334 -> 0xFFFFFFFB and 0x00000004 (wrap).
REQ-034 SHALL cover: 40 calls, rden_in held low -> rdy_out drops after FIFO_DEPTH total entries; release reads -> all 40 correct, in order.
REQ-035 SHALL cover: single call x=7 into empty block -> empty_out low exactly PIPE_LATENCY+1 cycles later with result 35.
REQ-036 SHALL cover: rst asserted with 5 results queued -> empty_out=1, rdy_out=0; rst_and_startup_done_out high 4 cycles after release.
REQ-037 SHALL cover (macro defined): load rate 4, stream 32768 calls -> rdy_out low 4 of every 8 cycles, all results correct.

Source files
------------

// File: rtl/exported_class_method_template_pkg.sv
// Types and constants shared by the TimesFive call block and its result queue.
package exported_class_method_template_pkg;

  typedef logic [31:0] uint32_t;

  localparam uint32_t MULT_CONST    = 32'd5;
  localparam int      STARTUP_DELAY = 4;

  function automatic uint32_t times_five(input uint32_t x);
    return uint32_t'(x * MULT_CONST);
  endfunction

endpackage

// File: rtl/exported_class_method_template_result_fifo.sv
// Show-ahead result queue: the head entry is always visible on head while not empty.
module ecmt_result_fifo
  import exported_class_method_template_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  uint32_t                    push_data,
  input  logic                       pop,
  output uint32_t                    head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

  uint32_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/exported_class_method_template.sv
// TimesFive(uint32) call block: pipelined x*5 feeding a show-ahead result FIFO.
// Optional stall injection is enabled by EXPORTED_CLASS_METHOD_TEMPLATE_STALL_INJECT_EN.
module exported_class_method_template
  import exported_class_method_template_pkg::*;
#(
  parameter int FIFO_DEPTH   = 32,
  parameter int PIPE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rst_and_startup_done_out,
  input  logic        TimesFive___uint_32___valid_in,
  input  logic [31:0] TimesFive___uint_32___x_in,
  output logic        TimesFive___uint_32___rdy_out,
  input  logic        TimesFive___uint_32___rden_in,
  output logic        TimesFive___uint_32___empty_out,
  output logic [31:0] TimesFive___uint_32___result_out,
  output logic        stall_rate_supported_out,
  input  logic        stall_rate_valid_in,
  input  logic [2:0]  stall_rate_in
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [PIPE_LATENCY-1:0] pipe_valid_reg;
  uint32_t                 pipe_data_reg [PIPE_LATENCY];
  logic [2:0]              startup_cnt_reg;
  logic                    startup_done;
  logic                    stall_active;
  logic                    accept;
  logic [31:0]             inflight;
  logic [31:0]             occupancy;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full_unused;

  assign startup_done = (startup_cnt_reg == 3'(STARTUP_DELAY));
  assign accept       = TimesFive___uint_32___valid_in && TimesFive___uint_32___rdy_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      startup_cnt_reg <= '0;
    end else if (!startup_done) begin
      startup_cnt_reg <= startup_cnt_reg + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_reg <= '0;
    end else begin
      pipe_valid_reg[0] <= accept;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
      end
    end
    pipe_data_reg[0] <= times_five(TimesFive___uint_32___x_in);
    for (int i = 1; i < PIPE_LATENCY; i++) begin
      pipe_data_reg[i] <= pipe_data_reg[i-1];
    end
  end

  // Credit covers both queued results and products still in the pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LATENCY; i++) begin
      inflight = inflight + 32'(pipe_valid_reg[i]);
    end
    occupancy = 32'(fifo_count) + inflight;
  end

`ifdef EXPORTED_CLASS_METHOD_TEMPLATE_STALL_INJECT_EN
  logic [2:0] stall_cnt_reg;
  logic [2:0] stall_rate_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg  <= '0;
      stall_rate_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_reg + 3'd1;
      if (stall_rate_valid_in) begin
        stall_rate_reg <= stall_rate_in;
      end
    end
  end

  assign stall_active             = (stall_cnt_reg < stall_rate_reg);
  assign stall_rate_supported_out = 1'b1;
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg         = ^{stall_rate_valid_in, stall_rate_in};
  assign stall_active             = 1'b0;
  assign stall_rate_supported_out = 1'b0;
`endif

  assign TimesFive___uint_32___rdy_out = startup_done && !stall_active &&
                                         (occupancy < 32'(FIFO_DEPTH));
  assign rst_and_startup_done_out      = startup_done;
  assign TimesFive___uint_32___empty_out = fifo_empty;

  ecmt_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .srst      (rst),
    .push      (pipe_valid_reg[PIPE_LATENCY-1]),
    .push_data (pipe_data_reg[PIPE_LATENCY-1]),
    .pop       (TimesFive___uint_32___rden_in),
    .head      (TimesFive___uint_32___result_out),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_exported_class_method_template.sv
// Self-checking bench for exported_class_method_template: vector table, timing sequences,
// and randomized streams scored against a queue of expected x*5 results.
module tb_exported_class_method_template;

  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] x;
  logic        rden;
  logic        stall_valid;
  logic [2:0]  stall_rate;
  logic        done;
  logic        rdy;
  logic        empty;
  logic [31:0] result;
  logic        supported;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] x;
    logic [31:0] expv;
  } vec_t;

  exported_class_method_template #(
    .FIFO_DEPTH   (DEPTH),
    .PIPE_LATENCY (LAT)
  ) dut (
    .clk                              (clk),
    .rst                              (rst),
    .rst_and_startup_done_out         (done),
    .TimesFive___uint_32___valid_in   (valid),
    .TimesFive___uint_32___x_in       (x),
    .TimesFive___uint_32___rdy_out    (rdy),
    .TimesFive___uint_32___rden_in    (rden),
    .TimesFive___uint_32___empty_out  (empty),
    .TimesFive___uint_32___result_out (result),
    .stall_rate_supported_out         (supported),
    .stall_rate_valid_in              (stall_valid),
    .stall_rate_in                    (stall_rate)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=bound_expired required=completion", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle scored against the expected-result queue.
  task automatic cycle(input logic v, input logic [31:0] xv, input logic rd, output logic acc);
    valid = v;
    x     = xv;
    rden  = rd;
    if (exp_q.size() == 0) check("empty_when_nothing_owed", {31'd0, empty}, 32'd1);
    acc = v && rdy;
    if (acc) begin
      check("rdy_within_credit", {31'd0, exp_q.size() < DEPTH}, 32'd1);
      exp_q.push_back(32'(64'(xv) * 64'd5));
    end
    if (rd && !empty) begin
      if (exp_q.size() == 0) fail_bound("spurious_result");
      else check("result_in_order", result, exp_q.pop_front());
    end
    step();
  endtask

  task automatic startup_check();
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("startup_done_edge%0d", k), {31'd0, done}, (k == 4) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    vec_t tbl [14];
    int   wi, ri, sent, cyc;
    logic acc;
    logic [7:0] hist;

    for (int i = 0; i < 10; i++) tbl[i] = '{x: 32'(i), expv: 32'(i * 5)};
    tbl[10] = '{x: 32'hFFFF_FFFF, expv: 32'hFFFF_FFFB};
    tbl[11] = '{x: 32'h3333_3334, expv: 32'h0000_0004};
    tbl[12] = '{x: 32'h8000_0000, expv: 32'h8000_0000};
    tbl[13] = '{x: 32'h1234_5678, expv: 32'h5B05_B058};

    rst = 1'b1; valid = 1'b0; x = '0; rden = 1'b0; stall_valid = 1'b0; stall_rate = '0;
    step(); step(); step();
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
`ifdef EXPORTED_CLASS_METHOD_TEMPLATE_STALL_INJECT_EN
    check("stall_supported", {31'd0, supported}, 32'd1);
`else
    check("stall_supported", {31'd0, supported}, 32'd0);
`endif
    rst = 1'b0;
    startup_check();
    $display("reset/startup sequence done");

    // Vector table, back-to-back calls, read whenever non-empty.
    wi = 0; ri = 0;
    for (int c = 0; c < 200 && ri < 14; c++) begin
      valid = (wi < 14);
      x     = (wi < 14) ? tbl[wi].x : 32'd0;
      rden  = 1'b1;
      if (!empty) begin
        check($sformatf("vector%0d", ri), result, tbl[ri].expv);
        $display("vector %0d x=0x%08h result=0x%08h", ri, tbl[ri].x, result);
        ri++;
      end
      if (valid && rdy) wi++;
      step();
    end
    valid = 1'b0; rden = 1'b0;
    if (ri < 14) fail_bound("vector_table");

    // Single call latency into an empty block.
    step();
    check("rdy_idle", {31'd0, rdy}, 32'd1);
    valid = 1'b1; x = 32'd7;
    step();
    valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k <= LAT) begin
        check($sformatf("latency_empty_k%0d", k), {31'd0, empty}, 32'd1);
        step();
      end else begin
        check("latency_visible", {31'd0, empty}, 32'd0);
        check("latency_result", result, 32'd35);
      end
    end
    rden = 1'b1; step(); rden = 1'b0;
    check("latency_popped_empty", {31'd0, empty}, 32'd1);
    $display("latency call x=7 done");

    // Fill with reads held off, then release.
    sent = 0;
    for (int c = 0; c < 120; c++) begin
      cycle(sent < 40, $urandom, 1'b0, acc);
      if (acc) sent++;
    end
    valid = 1'b0;
    check("fill_accepted", 32'(sent), 32'(DEPTH));
    check("fill_rdy_low", {31'd0, rdy}, 32'd0);
    check("fill_not_empty", {31'd0, empty}, 32'd0);
    for (int c = 0; c < 2000 && (sent < 40 || exp_q.size() > 0); c++) begin
      cycle(sent < 40, $urandom, 1'b1, acc);
      if (acc) sent++;
    end
    if (sent < 40 || exp_q.size() > 0) fail_bound("fill_drain");
    $display("fill/drain of 40 calls done");

    // Reset with five results queued.
    sent = 0;
    for (int c = 0; c < 50 && sent < 5; c++) begin
      cycle(1'b1, $urandom, 1'b0, acc);
      if (acc) sent++;
    end
    for (int c = 0; c < 5; c++) cycle(1'b0, 32'd0, 1'b0, acc);
    check("queued_not_empty", {31'd0, empty}, 32'd0);
    rst = 1'b1; step();
    check("midreset_empty", {31'd0, empty}, 32'd1);
    check("midreset_rdy", {31'd0, rdy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    startup_check();
    for (int c = 0; c < 10; c++) cycle(1'b0, 32'd0, 1'b1, acc);
    $display("mid-operation reset done");

    // Random traffic with arbitrary read stalls.
    sent = 0;
    for (int c = 0; c < 15000 && sent < 1500; c++) begin
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 2) == 0, acc);
      if (acc) sent++;
    end
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) cycle(1'b0, 32'd0, 1'b1, acc);
    if (sent < 1500 || exp_q.size() > 0) fail_bound("random_stream");
    $display("random stream of %0d calls done", sent);

`ifdef EXPORTED_CLASS_METHOD_TEMPLATE_STALL_INJECT_EN
    stall_valid = 1'b1; stall_rate = 3'd4;
    step();
    stall_valid = 1'b0;
    sent = 0; cyc = 0; hist = '0;
    for (int c = 0; c < 70000 && sent < 32768; c++) begin
      hist = {hist[6:0], rdy};
      cyc++;
      if (cyc % 8 == 0) begin
        checks++;
        if ($countones(hist) != 4) begin
          failures++;
          $display("FAIL stall_window actual=%0d required=4", $countones(hist));
        end
      end
      cycle(1'b1, $urandom, 1'b1, acc);
      if (acc) sent++;
    end
    stall_valid = 1'b1; stall_rate = 3'd0;
    step();
    stall_valid = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) cycle(1'b0, 32'd0, 1'b1, acc);
    if (sent < 32768 || exp_q.size() > 0) fail_bound("stall_stream");
    $display("stall-rate-4 stream of %0d calls done", sent);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
